// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with configurable access latency.
// Holds the pipeline with stall until the single outstanding access completes.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              req_any;
  logic              eff_rd, eff_wr;
  logic [31:0]       eff_addr;
  logic [DATA_W-1:0] eff_wdata;
  logic              illegal;
  logic              fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_idx;

  assign req_any = req_read | req_write;

  // In IDLE the access (zero-latency case) uses the live request; later it uses the latched copy
  always_comb begin
    if (state_q == S_IDLE) begin
      eff_rd    = req_read;
      eff_wr    = req_write;
      eff_addr  = req_addr;
      eff_wdata = req_wdata;
    end else begin
      eff_rd    = rd_q;
      eff_wr    = wr_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
    end
  end

  assign illegal = ((eff_addr >> ADDR_W) != 32'd0) || (eff_rd && eff_wr);
  assign fire    = ((state_q == S_IDLE) && req_any && (LATENCY == 0)) ||
                   ((state_q == S_WAIT) && (cnt_q == 4'd0));
  assign mem_we  = fire && eff_wr && !illegal && !reset;
  assign mem_idx = eff_addr[ADDR_W-1:0];

  assign stall      = ((state_q == S_IDLE) && req_any) || (state_q == S_WAIT);
  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;

  // Next-state, request latch and response computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          rd_d    = req_read;
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Access lands on the edge entering RESP; write responses keep old read data
    if (fire) begin
      valid_d = 1'b1;
      err_d   = illegal;
      if (illegal)     rdata_d = '0;
      else if (eff_rd) rdata_d = mem[mem_idx];
    end
  end

  // Control and response registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_idx] <= eff_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders at latencies 2, 0 and 4, table-driven
// accesses through a scoreboard plus hand-written multi-cycle sequences.
module tb_dmem_responder;

  localparam int NI = 3;

  logic clk;
  logic [NI-1:0] rst_i, rd_i, wr_i;
  logic [31:0]   addr_i  [NI];
  logic [31:0]   wdata_i [NI];
  logic          stall_o [NI];
  logic          valid_o [NI];
  logic          err_o   [NI];
  logic [31:0]   rdata_o [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_responder #(
      .ADDR_W (8),
      .LATENCY((g == 0) ? 2 : (g == 1) ? 0 : 4),
      .DATA_W (32)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_i[g]),
      .req_read  (rd_i[g]),
      .req_write (wr_i[g]),
      .req_addr  (addr_i[g]),
      .req_wdata (wdata_i[g]),
      .stall     (stall_o[g]),
      .resp_valid(valid_o[g]),
      .resp_rdata(rdata_o[g]),
      .resp_err  (err_o[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_chk  = 0;
  int n_pass = 0;

  function automatic int lat_of(input int idx);
    return (idx == 0) ? 2 : (idx == 1) ? 0 : 4;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one access, hold it while stalled, compare the response against the scoreboard.
  task automatic issue(input int idx, input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata,
                       input logic exp_err, input bit mutate);
    exp_t e;
    int   stalls;
    bit   got;
    sb.push_back('{rdata: exp_rdata, err: exp_err, stalls: lat_of(idx) + 1});
    stalls = 0;
    got    = 0;
    @(negedge clk);
    rd_i[idx]    = rd;
    wr_i[idx]    = wr;
    addr_i[idx]  = addr;
    wdata_i[idx] = wdata;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (valid_o[idx]) begin
        got = 1;
        break;
      end
      if (stall_o[idx]) stalls++;
      if (mutate && c == 1) begin
        addr_i[idx]  = addr + 32'd1;
        wdata_i[idx] = 32'hBBBB_BBBB;
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    if (!got) begin
      check($sformatf("resp_timeout[%0d]", idx), 32'd0, 32'd1);
    end else begin
      check($sformatf("rdata[%0d]@%h", idx, addr), rdata_o[idx], e.rdata);
      check($sformatf("err[%0d]@%h", idx, addr), 32'(err_o[idx]), 32'(e.err));
      check($sformatf("stall_cycles[%0d]", idx), 32'(stalls), 32'(e.stalls));
    end
    rd_i[idx] = 1'b0;
    wr_i[idx] = 1'b0;
    @(negedge clk);
    #1;
    check($sformatf("pulse_end[%0d]", idx), {30'd0, valid_o[idx], stall_o[idx]}, 32'd0);
  endtask

  initial begin
    int nresp, viol, prev;

    rst_i = '1;
    rd_i  = '0;
    wr_i  = '0;
    for (int i = 0; i < NI; i++) begin
      addr_i[i]  = 32'd0;
      wdata_i[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++)
      check($sformatf("reset_outs[%0d]", i),
            {rdata_o[i][29:0], valid_o[i], err_o[i]} | {31'd0, stall_o[i]}, 32'd0);
    @(negedge clk);
    rst_i = '0;

    // idx, rd, wr, addr, wdata, expected rdata, expected err
    vecs.push_back('{0, 1'b0, 1'b1, 32'd5,         32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'd5,         32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'd0,         32'h1111_0000, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'h100,       32'hFFFF_FFFF, 32'h0000_0000, 1'b1});
    vecs.push_back('{0, 1'b1, 1'b0, 32'd0,         32'h0,         32'h1111_0000, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'd3,         32'h3333_3333, 32'h1111_0000, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b1, 32'd3,         32'h0000_0BAD, 32'h0000_0000, 1'b1});
    vecs.push_back('{0, 1'b1, 1'b0, 32'd3,         32'h0,         32'h3333_3333, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'h8000_0001, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{0, 1'b0, 1'b1, 32'hFF,        32'hCAFE_F00D, 32'h0000_0000, 1'b0});
    vecs.push_back('{0, 1'b1, 1'b0, 32'hFF,        32'h0,         32'hCAFE_F00D, 1'b0});
    vecs.push_back('{0, 1'b0, 1'b1, 32'd11,        32'h0000_0011, 32'hCAFE_F00D, 1'b0});
    vecs.push_back('{1, 1'b0, 1'b1, 32'd5,         32'h1234_5678, 32'h0000_0000, 1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'd5,         32'h0,         32'h1234_5678, 1'b0});
    vecs.push_back('{1, 1'b0, 1'b1, 32'd6,         32'h0000_ABCD, 32'h1234_5678, 1'b0});
    vecs.push_back('{1, 1'b1, 1'b0, 32'd6,         32'h0,         32'h0000_ABCD, 1'b0});
    vecs.push_back('{2, 1'b0, 1'b1, 32'd7,         32'h0102_0304, 32'h0000_0000, 1'b0});
    vecs.push_back('{2, 1'b1, 1'b0, 32'd7,         32'h0,         32'h0102_0304, 1'b0});

    foreach (vecs[k])
      issue(vecs[k].idx, vecs[k].rd, vecs[k].wr, vecs[k].addr, vecs[k].wdata,
            vecs[k].exp_rdata, vecs[k].exp_err, 1'b0);

    // Request inputs change during WAIT: the latched address/data must be used
    issue(0, 1'b0, 1'b1, 32'd10, 32'h0A0A_0A0A, 32'hCAFE_F00D, 1'b0, 1'b1);
    issue(0, 1'b1, 1'b0, 32'd10, 32'h0, 32'h0A0A_0A0A, 1'b0, 1'b0);
    issue(0, 1'b1, 1'b0, 32'd11, 32'h0, 32'h0000_0011, 1'b0, 1'b0);

    // Zero latency, read held continuously: responses alternate with IDLE accept cycles
    nresp = 0;
    viol  = 0;
    prev  = 0;
    @(negedge clk);
    rd_i[1]   = 1'b1;
    addr_i[1] = 32'd5;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (valid_o[1]) begin
        nresp++;
        if (prev != 0 || stall_o[1] || rdata_o[1] !== 32'h1234_5678) viol++;
      end else if (!stall_o[1]) begin
        viol++;
      end
      prev = valid_o[1] ? 1 : 0;
      @(negedge clk);
    end
    rd_i[1] = 1'b0;
    check("b2b_resp_count", 32'(nresp), 32'd4);
    check("b2b_violations", 32'(viol), 32'd0);

    // Reset in the second WAIT cycle of a latency-4 write: write dropped, no response
    @(negedge clk);
    wr_i[2]    = 1'b1;
    addr_i[2]  = 32'd7;
    wdata_i[2] = 32'hA5A5_A5A5;
    repeat (2) @(negedge clk);
    #1;
    check("pre_reset_stall", 32'(stall_o[2]), 32'd1);
    rst_i[2] = 1'b1;
    wr_i[2]  = 1'b0;
    #1;
    check("reset_stall_valid", {30'd0, stall_o[2], valid_o[2]}, 32'd0);
    repeat (2) @(negedge clk);
    rst_i[2] = 1'b0;
    viol = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (valid_o[2] || stall_o[2]) viol++;
      @(negedge clk);
    end
    check("no_resp_after_reset", 32'(viol), 32'd0);
    issue(2, 1'b1, 1'b0, 32'd7, 32'h0, 32'h0102_0304, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
